piece_lock: RTL and testbench
=============================

# piece_lock

Upstream stage of the line-clear block. When the active tetromino lands, it latches the current board and the piece's four absolute cell coordinates, checks them for legality, and writes the cells into the board one per cycle. It then presents the merged board, plus a registered mask of full rows, for the line-clear stage to consume. An illegal lock raises a sticky game-over flag instead.

## Interface
Parameters:
- `BOARD_W`, default 10: board columns.
- `BOARD_H`, default 20: board rows; row 0 is the bottom row.
- `TYPE_BITS`, default 3: per-cell piece-type code width.
- `ROW_BITS`, default `BOARD_W*(1+TYPE_BITS)`: packed row width.
  - Row r occupies bits `[r*ROW_BITS +: ROW_BITS]`.
  - Fill bits are the low `BOARD_W` bits; bit c is column c.
  - Type codes follow, cell c at offset `BOARD_W + c*TYPE_BITS`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `lock_req`, in, 1: one-cycle request to lock the piece; sampled only in IDLE.
- `piece_type`, in, `TYPE_BITS`: type code written into all four cells.
- `cell_x`, in, 4x4 bits: column of cells 0..3, cell i at `[4i +: 4]`.
- `cell_y`, in, 4x5 bits: row of cells 0..3, cell i at `[5i +: 5]`.
- `cur_board`, in, `BOARD_H*ROW_BITS`: live board.
- `merged_board`, out, `BOARD_H*ROW_BITS`: board with the piece written in.
- `full_rows`, out, `BOARD_H`: bit r set when row r of `merged_board` is completely filled.
- `busy`, out, 1: lock in progress; upstream must not change the piece.
- `done`, out, 1: one-cycle pulse; `merged_board` and `full_rows` are valid.
- `game_over`, out, 1: sticky; set by an illegal lock.

## Operation
- State machine states: IDLE, CHECK, WRITE, DONE, OVER.
- **IDLE:**
  - On `lock_req`, latch `cur_board` into `merged_board`, and latch `cell_x`, `cell_y` and `piece_type`.
  - Go to CHECK.
- **CHECK:** a cell is illegal if any of the following holds:
  - x ≥ `BOARD_W`;
  - y ≥ `BOARD_H` (lock-out above the top);
  - its fill bit in the latched board is already 1.
- **CHECK transitions:**
  - Any illegal cell: go to OVER; `merged_board` is left unmodified.
  - Otherwise: clear the 2-bit cell index and go to WRITE.
- **WRITE:** each cycle, for cell[idx]:
  - set its fill bit;
  - set its type field to `piece_type`;
  - increment idx;
  - after idx = 3, go to DONE.
- Two cells with identical coordinates are legal. The second write simply rewrites the same cell.
- **DONE:**
  - Register `full_rows` as the AND of each row's fill bits of the final `merged_board`.
  - Pulse `done` for one cycle and return to IDLE.
- **OVER:**
  - `game_over` = 1 and `busy` = 0.
  - All `lock_req` are ignored until `rst`.
- `merged_board` and `full_rows` hold their values from `done` until the next accepted `lock_req`.
- `cur_board` is not sampled again after acceptance, so it may change freely while `busy`.

## Timing
- Reset (async, immediate) forces:
  - state = IDLE;
  - `merged_board` = 0, `full_rows` = 0;
  - `busy` = 0, `done` = 0, `game_over` = 0.
- Reset mid-lock aborts with no partial write visible after reset.
- Latency, with `lock_req` sampled at edge T0:
  - `busy` = 1 from T0+ through the DONE cycle.
  - CHECK occupies T1.
  - WRITE occupies T2..T5.
  - DONE occupies T6: `done` = 1 during T6 and `merged_board` is final at T6.
  - `full_rows` is valid in the same cycle as `done`.
- Total: 6 cycles from accept to `done`, then 1 cycle back in IDLE.
- The earliest next accept is the edge ending the IDLE cycle after DONE, i.e. 7 cycles minimum between `lock_req` pulses.
- `lock_req` while `busy`, in DONE, or in OVER is dropped; it is not queued.
- Illegal lock: `game_over` rises at T2 (registered from CHECK), `busy` falls at T2, and `done` never pulses.

## Test plan
- **Clean lock:** empty board, O-piece cells (4,0),(5,0),(4,1),(5,1), type 3, `lock_req` at T0.
  - `done` at T6 only.
  - Rows 0–1 fill bits = 0x030; those cells' type = 3; all other bits 0.
  - `full_rows` = 0, `busy` high T1–T6.
- **Row completion:** row 0 fill = 0x3F0 (cols 4–9), I-piece at (0..3,0).
  - Row 0 fill = 0x3FF; `full_rows` = 20'h00001.
- **Overlap:** (5,0) already filled, piece includes (5,0).
  - `game_over` = 1 at T2; `done` never pulses; `merged_board` equals the latched board.
  - A later `lock_req` has no effect until `rst`.
- **Out of range:** one cell at y = 20, a second test with x = 10.
  - Each raises `game_over`, no write.
- **Dropped request and board isolation:**
  - Second `lock_req` at T3 is ignored: exactly one `done`.
  - `cur_board` changed at T2 does not alter `merged_board`.
- **Reset mid-write:** assert `rst` at T4.
  - All outputs 0 immediately; a subsequent clean lock completes normally in 6 cycles.

Source files
------------

// File: rtl/piece_lock.sv
`default_nettype none
// ============================================================================
// Module   : piece_lock
// Purpose  : Locks the landed tetromino into the board. On lock_req it
//            latches the live board and the piece, checks the four cells for
//            legality, writes them one per cycle, then presents the merged
//            board with a registered mask of completely filled rows. An
//            illegal lock parks the block in a sticky game-over state.
// Ports    : clk, rst (async, active-high)
//            lock_req            - one-cycle lock request (sampled in IDLE)
//            piece_type          - type code written into all four cells
//            cell_x / cell_y     - packed column (4b) / row (5b) of cells 0..3
//            cur_board           - live board, sampled only on accept
//            merged_board        - board with the piece written in
//            full_rows           - bit r set when row r is completely filled
//            busy / done         - lock in progress / one-cycle result strobe
//            game_over           - sticky illegal-lock flag
// Revision : 1.0 - initial release
// ============================================================================
module piece_lock #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int TYPE_BITS = 3,
  parameter int ROW_BITS  = BOARD_W * (1 + TYPE_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lock_req,
  input  logic [TYPE_BITS-1:0]        piece_type,
  input  logic [15:0]                 cell_x,
  input  logic [19:0]                 cell_y,
  input  logic [BOARD_H*ROW_BITS-1:0] cur_board,
  output logic [BOARD_H*ROW_BITS-1:0] merged_board,
  output logic [BOARD_H-1:0]          full_rows,
  output logic                        busy,
  output logic                        done,
  output logic                        game_over
);

  localparam int BOARD_BITS = BOARD_H * ROW_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             idx;
  logic [15:0]            lat_x;
  logic [19:0]            lat_y;
  logic [TYPE_BITS-1:0]   lat_type;
  logic                   illegal;
  logic [BOARD_BITS-1:0]  write_board;
  logic [BOARD_H-1:0]     write_full;

  // Legality of the latched piece against the latched board. Out-of-range
  // coordinates short-circuit the occupancy lookup so it never indexes
  // beyond the board.
  always_comb begin
    int cx, cy;
    illegal = 1'b0;
    cx      = 0;
    cy      = 0;
    for (int i = 0; i < 4; i++) begin
      cx = int'(lat_x[4*i +: 4]);
      cy = int'(lat_y[5*i +: 5]);
      if (cx >= BOARD_W || cy >= BOARD_H) begin
        illegal = 1'b1;
      end else if (merged_board[cy*ROW_BITS + cx]) begin
        illegal = 1'b1;
      end
    end
  end

  // Board after writing cell[idx]; full-row mask is taken from this image so
  // it is already valid in the DONE cycle.
  always_comb begin
    int wx, wy;
    wx          = int'(lat_x[4*int'(idx) +: 4]);
    wy          = int'(lat_y[5*int'(idx) +: 5]);
    write_board = merged_board;
    if (wx < BOARD_W && wy < BOARD_H) begin
      write_board[wy*ROW_BITS + wx] = 1'b1;
      write_board[wy*ROW_BITS + BOARD_W + wx*TYPE_BITS +: TYPE_BITS] = lat_type;
    end
    write_full = '0;
    for (int r = 0; r < BOARD_H; r++) begin
      write_full[r] = &write_board[r*ROW_BITS +: BOARD_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    game_over  = 1'b0;
    case (state)
      IDLE: begin
        if (lock_req) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = illegal ? OVER : WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (idx == 2'd3) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      OVER: begin
        game_over  = 1'b1;
        state_next = OVER;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merged_board <= '0;
      full_rows    <= '0;
      idx          <= 2'd0;
      lat_x        <= '0;
      lat_y        <= '0;
      lat_type     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_req) begin
            merged_board <= cur_board;
            full_rows    <= '0;
            lat_x        <= cell_x;
            lat_y        <= cell_y;
            lat_type     <= piece_type;
          end
        end
        CHECK: idx <= 2'd0;
        WRITE: begin
          merged_board <= write_board;
          idx          <= idx + 2'd1;
          if (idx == 2'd3) full_rows <= write_full;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piece_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_lock
// Purpose  : Scoreboard bench for piece_lock. Stimulus pushes the expected
//            outcome of each lock (result or game-over, board, row mask,
//            cycle); a monitor pops and compares on done / game_over rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piece_lock;

  localparam int BW = 800;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lock_req = 1'b0;
  logic [2:0]      piece_type = '0;
  logic [15:0]     cell_x = '0;
  logic [19:0]     cell_y = '0;
  logic [BW-1:0]   cur_board = '0;
  logic [BW-1:0]   merged_board;
  logic [19:0]     full_rows;
  logic            busy, done, game_over;

  piece_lock dut (
    .clk(clk), .rst(rst), .lock_req(lock_req), .piece_type(piece_type),
    .cell_x(cell_x), .cell_y(cell_y), .cur_board(cur_board),
    .merged_board(merged_board), .full_rows(full_rows),
    .busy(busy), .done(done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            over;
    logic [BW-1:0] board;
    logic [19:0]   fr;
    int            at;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   go_prev = 1'b0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic board_chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < 20; r++) begin
        if (act[r*40 +: 40] !== exp[r*40 +: 40]) begin
          $display("FAIL %s row %0d: got %h expected %h", nm, r, act[r*40 +: 40], exp[r*40 +: 40]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int x, input int y,
                                        input logic [2:0] t);
    logic [BW-1:0] r;
    r = b;
    r[y*40 + x] = 1'b1;
    r[y*40 + 10 + x*3 +: 3] = t;
    return r;
  endfunction

  task automatic check_out(input bit over);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: got over=%0d at cycle %0d expected none", over, cyc);
    end else begin
      e = sbq.pop_front();
      chk("outcome_kind", over, e.over);
      chk("outcome_cycle", cyc, e.at);
      board_chk("merged_board", merged_board, e.board);
      if (!over) chk("full_rows", full_rows, e.fr);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      go_prev = 1'b0;
    end else begin
      if (done) check_out(1'b0);
      if (game_over && !go_prev) check_out(1'b1);
      go_prev = game_over;
    end
  end

  // Presents a piece and pulses lock_req across one edge; returns the cycle
  // count just after the accepting edge (T0).
  task automatic do_lock(input logic [2:0] t,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int x3, input int y3,
                         input logic [BW-1:0] brd, output int t0);
    @(negedge clk);
    cur_board  = brd;
    piece_type = t;
    cell_x     = {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
    cell_y     = {5'(y3), 5'(y2), 5'(y1), 5'(y0)};
    lock_req   = 1'b1;
    @(posedge clk);
    #1;
    lock_req = 1'b0;
    t0 = cyc;
  endtask

  task automatic push(input bit over, input logic [BW-1:0] b, input logic [19:0] fr, input int at);
    exp_t e;
    e.over = over; e.board = b; e.fr = fr; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic settle(input string nm);
    repeat (10) @(negedge clk);
    chk(nm, sbq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] b, e;
    int t0;

    #1;
    chk("reset_merged_zero", (merged_board == '0), 1);
    chk("reset_full_rows", full_rows, 0);
    chk("reset_flags", {busy, done, game_over}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean O-piece on an empty board.
    b = '0;
    e = put(put(put(put(b, 4, 0, 3'd3), 5, 0, 3'd3), 4, 1, 3'd3), 5, 1, 3'd3);
    do_lock(3'd3, 4, 0, 5, 0, 4, 1, 5, 1, b, t0);
    push(1'b0, e, 20'h0, t0 + 5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("busy_during_lock", busy, 1);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("row0_fill", merged_board[9:0], 10'h030);
    chk("row1_fill", merged_board[49:40], 10'h030);
    chk("cell_4_0_type", merged_board[22 +: 3], 3'd3);
    settle("clean_pending");

    // Row completion with an I-piece.
    b = '0;
    b[9:0] = 10'h3F0;
    e = put(put(put(put(b, 0, 0, 3'd1), 1, 0, 3'd1), 2, 0, 3'd1), 3, 0, 3'd1);
    do_lock(3'd1, 0, 0, 1, 0, 2, 0, 3, 0, b, t0);
    push(1'b0, e, 20'h00001, t0 + 5);
    settle("rowfill_pending");
    chk("row0_full_fill", merged_board[9:0], 10'h3FF);

    // Duplicate coordinates and the extreme legal corners.
    b = '0;
    e = put(put(put(b, 9, 19, 3'd7), 0, 19, 3'd7), 0, 0, 3'd7);
    do_lock(3'd7, 9, 19, 9, 19, 0, 19, 0, 0, b, t0);
    push(1'b0, e, 20'h0, t0 + 5);
    settle("corner_pending");

    // Dropped second request and board isolation.
    b = '0;
    b[19:10] = 10'h2AA;
    e = put(put(put(put(b, 0, 5, 3'd5), 1, 5, 3'd5), 2, 5, 3'd5), 1, 6, 3'd5);
    do_lock(3'd5, 0, 5, 1, 5, 2, 5, 1, 6, b, t0);
    push(1'b0, e, 20'h0, t0 + 5);
    @(posedge clk); #1;
    cur_board = '1;
    @(posedge clk); #1;
    lock_req = 1'b1;
    @(posedge clk); #1;
    lock_req = 1'b0;
    settle("dropped_pending");

    // Reset during the write phase, then a clean lock.
    b = '0;
    do_lock(3'd2, 4, 0, 5, 0, 4, 1, 5, 1, b, t0);
    push(1'b0, b, 20'h0, t0 + 5);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("midreset_merged_zero", (merged_board == '0), 1);
    chk("midreset_flags", {busy, done, game_over, (full_rows == '0)}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    e = put(put(put(put(b, 4, 0, 3'd2), 5, 0, 3'd2), 4, 1, 3'd2), 5, 1, 3'd2);
    do_lock(3'd2, 4, 0, 5, 0, 4, 1, 5, 1, b, t0);
    push(1'b0, e, 20'h0, t0 + 5);
    settle("postreset_pending");

    // Lock-out above the top row.
    b = '0;
    b[9:0] = 10'h00F;
    do_lock(3'd3, 4, 19, 5, 19, 4, 20, 5, 20, b, t0);
    push(1'b1, b, 20'h0, t0 + 1);
    @(negedge clk);
    chk("over_y_busy_t1", busy, 1);
    @(negedge clk);
    chk("over_y_flags_t2", {busy, game_over}, 2'b01);
    settle("over_y_pending");
    do_reset();

    // Column out of range.
    b = '0;
    b[49:40] = 10'h101;
    do_lock(3'd4, 8, 3, 9, 3, 10, 3, 10, 4, b, t0);
    push(1'b1, b, 20'h0, t0 + 1);
    settle("over_x_pending");
    chk("over_x_sticky", game_over, 1);
    do_reset();

    // Overlap with an occupied cell; later requests are ignored.
    b = put('0, 5, 0, 3'd2);
    do_lock(3'd3, 4, 0, 5, 0, 4, 1, 5, 1, b, t0);
    push(1'b1, b, 20'h0, t0 + 1);
    settle("overlap_pending");
    do_lock(3'd1, 0, 2, 1, 2, 2, 2, 3, 2, '0, t0);
    settle("over_ignored_pending");
    chk("over_ignored_flags", {busy, game_over}, 2'b01);
    board_chk("over_board_kept", merged_board, b);
    do_reset();
    chk("over_cleared_by_reset", game_over, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
